amm_slave_mailbox: RTL and testbench
====================================

AMM_SLAVE_MAILBOX -- requirements
Module: amm_slave_mailbox

Interface
REQ-001 The module SHALL have parameter DATAWIDTH, default 32, meaning Avalon data width.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 16 (power of two), meaning mailbox FIFO entries.
REQ-003 The module SHALL have port clk  in  1  sole clock, all logic on its rising edge.
REQ-004 The module SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port avs_address  in  3  word address.
REQ-006 The module SHALL have ports avs_read, avs_write  in  1 each  Avalon-MM slave commands.
REQ-007 The module SHALL have ports avs_writedata  in  DATAWIDTH and avs_byteenable  in  DATAWIDTH/8.
REQ-008 The module SHALL have ports avs_readdata  out  DATAWIDTH and avs_readdatavalid  out  1.
REQ-009 The module SHALL have port avs_waitrequest  out  1  stall.
REQ-010 The module SHALL have port coe_switches  in  18  raw board switches.
REQ-011 The module SHALL have port coe_key_n  in  1  raw active-low pushbutton.
REQ-012 The module SHALL have port coe_display_data  out  32  value for the eight hex digits.
REQ-013 The module SHALL have port irq  out  1  level interrupt.

Function
REQ-014 Register map: 0 CTRL (RW), 1 DISPLAY (RW), 2 SWITCH (RO), 3 FIFO_DATA (W push / R pop), 4 STATUS (RO), 5 KEYCNT (RO, any write clears); addresses 6-7 SHALL read 0 and ignore writes.
REQ-015 CTRL fields: [7:0] irq threshold, [30] overflow-irq enable, [31] level-irq enable; other bits SHALL read 0.
REQ-016 Writes to CTRL and DISPLAY SHALL honour avs_byteenable per byte; FIFO_DATA push SHALL store the full word regardless of byteenable.
REQ-017 coe_display_data SHALL equal the DISPLAY register.
REQ-018 STATUS fields: [7:0] FIFO level, [8] empty, [9] full, [10] overflow sticky; writing 1 to STATUS[10] SHALL clear the sticky flag.
REQ-019 Push while full SHALL discard the data, leave the FIFO unchanged and set overflow sticky.
REQ-020 Pop while empty SHALL return 0 and leave pointers unchanged.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH; level SHALL be log2(FIFO_DEPTH)+1 bits wide, reaching FIFO_DEPTH when full.
REQ-022 Reads SHALL be pipelined with fixed latency 2: avs_readdatavalid high exactly 2 cycles after an accepted read, one cycle wide, with avs_readdata valid in that cycle, otherwise 0.
REQ-023 A read is accepted when avs_read=1 and avs_waitrequest=0; back-to-back reads SHALL be accepted every cycle.
REQ-024 FIFO pop SHALL occur in the accept cycle, so a following STATUS read reflects it.
REQ-025 avs_read and avs_write both high: write SHALL execute, read SHALL be ignored with no readdatavalid.
REQ-026 avs_waitrequest SHALL be high from reset through 4 cycles after reset_n deasserts (INIT state), then low (RUN state); no other transitions.
REQ-027 coe_switches and coe_key_n SHALL each pass a 2-flop synchronizer; SWITCH reads the synchronized value zero-extended.
REQ-028 A synchronized key falling edge SHALL increment KEYCNT (16 bits, saturating at 0xFFFF); a clearing write and an edge in the same cycle SHALL leave KEYCNT = 1.
REQ-029 irq SHALL be registered: high when (CTRL[31] and level >= threshold and threshold != 0) or (CTRL[30] and overflow sticky).
REQ-030 Simultaneous push and pop on a non-full, non-empty FIFO is impossible (one command per cycle); push on full with pop in flight still SHALL count as full.

Reset
REQ-031 On reset_n low all registers, pointers, KEYCNT, synchronizers, read pipeline and irq SHALL clear to 0, avs_waitrequest SHALL be 1, coe_display_data SHALL be 0.
REQ-032 Reset asserted mid-read SHALL cancel the pending readdatavalid.

Structure
REQ-033 Register address constants, CTRL/STATUS bit positions and the INIT/RUN state enum SHALL live in package amm_mailbox_pkg.
REQ-034 The FIFO SHALL be sub-module mailbox_fifo (storage, pointers, level, full/empty).

Verification
REQ-035 Reset release -> waitrequest 1 for 4 cycles, then 0; all reads return 0 except STATUS=0x100.
REQ-036 Write DISPLAY 0x12345678 with byteenable 0b0101 from 0 -> coe_display_data 0x00340078; read returns it 2 cycles later.
REQ-037 Push 16 words 1..16, push 17th -> STATUS=0x610; pops return 1..16 in order, 17th pop returns 0, STATUS=0x500.
REQ-038 CTRL=0x80000004, push 4 words -> irq rises 1 cycle after 4th push; one pop -> irq falls.
REQ-039 Three coe_key_n low pulses (each >=3 cycles) -> KEYCNT=3; write KEYCNT during a fourth edge -> KEYCNT=1.
REQ-040 Reset asserted one cycle after a read accept -> no readdatavalid pulse.

Source files
------------

// File: rtl/amm_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amm_mailbox_pkg
// Description : Register map, bit positions and run-state type shared by the
//               Avalon-MM mailbox slave and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package amm_mailbox_pkg;

    localparam logic [2:0] c_ADDR_CTRL    = 3'd0;
    localparam logic [2:0] c_ADDR_DISPLAY = 3'd1;
    localparam logic [2:0] c_ADDR_SWITCH  = 3'd2;
    localparam logic [2:0] c_ADDR_FIFO    = 3'd3;
    localparam logic [2:0] c_ADDR_STATUS  = 3'd4;
    localparam logic [2:0] c_ADDR_KEYCNT  = 3'd5;

    localparam int c_CTRL_OVF_IE  = 30;
    localparam int c_CTRL_LVL_IE  = 31;
    localparam int c_STAT_EMPTY   = 8;
    localparam int c_STAT_FULL    = 9;
    localparam int c_STAT_OVF     = 10;

    localparam logic [31:0] c_CTRL_MASK   = 32'hC000_00FF;
    localparam logic [1:0]  c_INIT_LAST   = 2'd3;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mb_state_t;

endpackage
`default_nettype wire

// File: rtl/mailbox_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mailbox_fifo
// Description : Power-of-two FIFO with occupancy level; pushes when full and
//               pops when empty are ignored, empty reads return zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mailbox_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == (AW+1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/amm_slave_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : amm_slave_mailbox
// Description : Avalon-MM slave with control/display registers, synchronized
//               board inputs, key press counter, mailbox FIFO and interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module amm_slave_mailbox
    import amm_mailbox_pkg::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [2:0]             avs_address,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [DATAWIDTH-1:0]   avs_writedata,
    input  logic [DATAWIDTH/8-1:0] avs_byteenable,
    output logic [DATAWIDTH-1:0]   avs_readdata,
    output logic                   avs_readdatavalid,
    output logic                   avs_waitrequest,
    input  logic [17:0]            coe_switches,
    input  logic                   coe_key_n,
    output logic [31:0]            coe_display_data,
    output logic                   irq
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATAWIDTH-1:0] c_CTRL_WMASK = DATAWIDTH'(c_CTRL_MASK);

    mb_state_t            r_state;
    logic [1:0]           r_init_cnt;
    logic [DATAWIDTH-1:0] r_ctrl;
    logic [DATAWIDTH-1:0] r_display;
    logic                 r_ovf;
    logic [15:0]          r_keycnt;
    logic [17:0]          r_sw_s1;
    logic [17:0]          r_sw_s2;
    logic                 r_key_s1;
    logic                 r_key_s2;
    logic                 r_key_d;
    logic                 r_rd_v1;
    logic [DATAWIDTH-1:0] r_rd_d1;

    logic [DATAWIDTH-1:0] w_be_mask;
    logic [DATAWIDTH-1:0] w_rd_mux;
    logic [DATAWIDTH-1:0] w_status;
    logic [DATAWIDTH-1:0] w_fifo_rdata;
    logic [LVL_W-1:0]     w_level;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_key_fall;

    generate
        for (genvar gi = 0; gi < DATAWIDTH/8; gi++) begin : g_be
            assign w_be_mask[8*gi +: 8] = {8{avs_byteenable[gi]}};
        end
    endgenerate

    // A simultaneous read and write executes only the write.
    assign w_wr_acc   = avs_write & ~avs_waitrequest;
    assign w_rd_acc   = avs_read & ~avs_write & ~avs_waitrequest;
    assign w_push     = w_wr_acc & (avs_address == c_ADDR_FIFO);
    assign w_pop      = w_rd_acc & (avs_address == c_ADDR_FIFO);
    assign w_key_fall = r_key_d & ~r_key_s2;

    assign coe_display_data = r_display[31:0];

    mailbox_fifo #(
        .WIDTH (DATAWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .wdata   (avs_writedata),
        .rdata   (w_fifo_rdata),
        .level   (w_level),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_INIT;
            r_init_cnt      <= '0;
            avs_waitrequest <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == c_INIT_LAST) begin
                        r_state         <= ST_RUN;
                        avs_waitrequest <= 1'b0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                ST_RUN:  avs_waitrequest <= 1'b0;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl    <= '0;
            r_display <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr_acc && avs_address == c_ADDR_CTRL) begin
                r_ctrl <= ((r_ctrl & ~w_be_mask) | (avs_writedata & w_be_mask)) & c_CTRL_WMASK;
            end
            if (w_wr_acc && avs_address == c_ADDR_DISPLAY) begin
                r_display <= (r_display & ~w_be_mask) | (avs_writedata & w_be_mask);
            end
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr_acc && avs_address == c_ADDR_STATUS && avs_writedata[c_STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_key_s1 <= 1'b0;
            r_key_s2 <= 1'b0;
            r_key_d  <= 1'b0;
            r_keycnt <= '0;
        end else begin
            r_sw_s1  <= coe_switches;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= coe_key_n;
            r_key_s2 <= r_key_s1;
            r_key_d  <= r_key_s2;
            // A clear racing a key edge keeps that edge as the first count.
            if (w_wr_acc && avs_address == c_ADDR_KEYCNT) begin
                r_keycnt <= w_key_fall ? 16'd1 : 16'd0;
            end else if (w_key_fall && r_keycnt != 16'hFFFF) begin
                r_keycnt <= r_keycnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_status               = '0;
        w_status[7:0]          = 8'(w_level);
        w_status[c_STAT_EMPTY] = w_empty;
        w_status[c_STAT_FULL]  = w_full;
        w_status[c_STAT_OVF]   = r_ovf;
    end

    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            c_ADDR_CTRL:    w_rd_mux = r_ctrl;
            c_ADDR_DISPLAY: w_rd_mux = r_display;
            c_ADDR_SWITCH:  w_rd_mux = DATAWIDTH'(r_sw_s2);
            c_ADDR_FIFO:    w_rd_mux = w_fifo_rdata;
            c_ADDR_STATUS:  w_rd_mux = w_status;
            c_ADDR_KEYCNT:  w_rd_mux = DATAWIDTH'(r_keycnt);
            default:        w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_v1           <= 1'b0;
            r_rd_d1           <= '0;
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
            irq               <= 1'b0;
        end else begin
            r_rd_v1           <= w_rd_acc;
            r_rd_d1           <= w_rd_acc ? w_rd_mux : '0;
            avs_readdatavalid <= r_rd_v1;
            avs_readdata      <= r_rd_v1 ? r_rd_d1 : '0;
            irq <= (r_ctrl[c_CTRL_LVL_IE] && (r_ctrl[7:0] != 8'd0) &&
                    (16'(w_level) >= 16'(r_ctrl[7:0]))) ||
                   (r_ctrl[c_CTRL_OVF_IE] && r_ovf);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_amm_slave_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_amm_slave_mailbox
// Description : Directed self-checking bench for the Avalon-MM mailbox slave.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_amm_slave_mailbox;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;
    logic [17:0] coe_switches;
    logic        coe_key_n;
    logic [31:0] coe_display_data;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    amm_slave_mailbox #(
        .DATAWIDTH  (32),
        .FIFO_DEPTH (16)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .coe_switches      (coe_switches),
        .coe_key_n         (coe_key_n),
        .coe_display_data  (coe_display_data),
        .irq               (irq)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        avs_write      = 1'b1;
        tick();
        avs_write      = 1'b0;
        avs_byteenable = 4'hF;
    endtask

    task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        tick();
        chk({tag, "_v"}, {31'd0, avs_readdatavalid}, 32'd1);
        chk(tag, avs_readdata, exp);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 10 && avs_waitrequest; i++) tick();
        chk("ready", {31'd0, avs_waitrequest}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = 4'hF; coe_switches = '0; coe_key_n = 1'b1;
        repeat (3) tick();
        chk("rst_wait", {31'd0, avs_waitrequest}, 32'd1);
        chk("rst_disp", coe_display_data, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdv", {31'd0, avs_readdatavalid}, 32'd0);

        reset_n = 1'b1;
        chk("init_w0", {31'd0, avs_waitrequest}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("init_w", {31'd0, avs_waitrequest}, 32'd1);
        end
        tick();
        chk("run_w", {31'd0, avs_waitrequest}, 32'd0);

        for (int a = 0; a < 8; a++) begin
            read_chk("rst_reg", 3'(a), (a == 4) ? 32'h100 : 32'h0);
        end

        bus_write(3'd1, 32'h1234_5678, 4'b0101);
        chk("disp_be", coe_display_data, 32'h0034_0078);
        read_chk("disp_rd", 3'd1, 32'h0034_0078);

        bus_write(3'd0, 32'hFFFF_FFFF, 4'hF);
        read_chk("ctrl_mask", 3'd0, 32'hC000_00FF);
        bus_write(3'd0, 32'h0, 4'hF);
        bus_write(3'd6, 32'hFFFF_FFFF, 4'hF);
        read_chk("addr6", 3'd6, 32'h0);

        coe_switches = 18'h2ABCD;
        repeat (3) tick();
        read_chk("switch", 3'd2, 32'h0002_ABCD);

        for (int i = 1; i <= 16; i++) bus_write(3'd3, 32'(i), 4'h0);
        bus_write(3'd3, 32'h99, 4'hF);
        read_chk("stat_full", 3'd4, 32'h610);
        for (int i = 1; i <= 16; i++) read_chk("pop", 3'd3, 32'(i));
        read_chk("pop_empty", 3'd3, 32'h0);
        read_chk("stat_empty", 3'd4, 32'h500);
        bus_write(3'd4, 32'h400, 4'hF);
        read_chk("stat_clr", 3'd4, 32'h100);

        // Back-to-back reads: two pops then a STATUS that must see both.
        bus_write(3'd3, 32'hA, 4'hF);
        bus_write(3'd3, 32'hB, 4'hF);
        avs_address = 3'd3; avs_read = 1'b1;
        tick();
        tick();
        chk("b2b_v1", {31'd0, avs_readdatavalid}, 32'd1);
        chk("b2b_d1", avs_readdata, 32'hA);
        avs_address = 3'd4;
        tick();
        chk("b2b_d2", avs_readdata, 32'hB);
        avs_read = 1'b0;
        tick();
        chk("b2b_stat", avs_readdata, 32'h100);
        tick();
        chk("b2b_vend", {31'd0, avs_readdatavalid}, 32'd0);
        chk("b2b_dend", avs_readdata, 32'h0);

        avs_address = 3'd1; avs_writedata = 32'hCAFE_F00D; avs_byteenable = 4'hF;
        avs_write = 1'b1; avs_read = 1'b1;
        tick();
        avs_write = 1'b0; avs_read = 1'b0;
        chk("rw_disp", coe_display_data, 32'hCAFE_F00D);
        tick();
        chk("rw_v1", {31'd0, avs_readdatavalid}, 32'd0);
        tick();
        chk("rw_v2", {31'd0, avs_readdatavalid}, 32'd0);

        bus_write(3'd0, 32'h8000_0004, 4'hF);
        for (int i = 0; i < 4; i++) bus_write(3'd3, 32'h10 + 32'(i), 4'hF);
        chk("irq_pre", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_rise", {31'd0, irq}, 32'd1);
        read_chk("irq_pop", 3'd3, 32'h10);
        chk("irq_fall", {31'd0, irq}, 32'd0);
        bus_write(3'd0, 32'h0, 4'hF);

        for (int p = 0; p < 3; p++) begin
            coe_key_n = 1'b0;
            repeat (4) tick();
            coe_key_n = 1'b1;
            repeat (4) tick();
        end
        read_chk("keycnt3", 3'd5, 32'd3);
        coe_key_n = 1'b0;
        tick();
        tick();
        bus_write(3'd5, 32'h0, 4'hF);
        repeat (3) tick();
        coe_key_n = 1'b1;
        repeat (4) tick();
        read_chk("keycnt_clr", 3'd5, 32'd1);

        // Reset lands in the cycle right after the read is accepted.
        avs_address = 3'd1; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        reset_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_cancel", {31'd0, avs_readdatavalid}, 32'd0);
        end
        reset_n = 1'b1;
        chk("rst2_wait", {31'd0, avs_waitrequest}, 32'd1);
        wait_ready();
        read_chk("rst2_disp", 3'd1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
